// File: rtl/memcontrol_pkg.sv
// Shared constants and geometry helpers for the multi-port line-cache front end.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package memcontrol_pkg;

    // Controller states.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOOKUP = 3'd1;
    localparam logic [2:0] ST_FILL   = 3'd2;
    localparam logic [2:0] ST_WRITE  = 3'd3;
    localparam logic [2:0] ST_RETRY  = 3'd4;

    // Number of cache lines.
    function automatic int line_depth(input int cache_depth);
        return 1 << cache_depth;
    endfunction

    // Number of requester words per cache line.
    function automatic int word_depth(input int line_w, input int word_w);
        return line_w / word_w;
    endfunction

    // Width of the byte offset within a line.
    function automatic int off_width(input int line_w, input int gran);
        return $clog2(line_w / gran);
    endfunction

    // Tag bits left above offset and index.
    function automatic int tag_width(input int addr_w, input int line_w,
                                     input int gran, input int cache_depth);
        return addr_w - off_width(line_w, gran) - cache_depth;
    endfunction

endpackage

// File: rtl/memcontrol_mp_if.sv
// Requester, invalidate and Wishbone signals of the multi-port cache front end.
// Latency: n/a (wiring only).
// Backpressure: req_ready per port; Wishbone ack/err/rty end each bus transaction.
interface memcontrol_mp_if #(
    parameter int NPORTS           = 2,
    parameter int ADDR_WIDTH       = 32,
    parameter int WORD_WIDTH       = 32,
    parameter int LINE_WIDTH       = 128,
    parameter int ADDR_GRANULARITY = 8
);
    localparam int BPW = WORD_WIDTH / ADDR_GRANULARITY;
    localparam int BPL = LINE_WIDTH / ADDR_GRANULARITY;

    logic [NPORTS-1:0]            req_valid;
    logic [NPORTS-1:0]            req_ready;
    logic [NPORTS*ADDR_WIDTH-1:0] req_addr;
    logic [NPORTS-1:0]            req_wr;
    logic [NPORTS*WORD_WIDTH-1:0] req_wdata;
    logic [NPORTS*BPW-1:0]        req_sel;
    logic [NPORTS-1:0]            rsp_valid;
    logic [WORD_WIDTH-1:0]        rsp_rdata;
    logic                         rsp_err;
    logic                         inv_valid;
    logic [ADDR_WIDTH-1:0]        inv_addr;
    logic [ADDR_WIDTH-1:0]        wb_adr_o;
    logic [LINE_WIDTH-1:0]        wb_dat_o;
    logic [LINE_WIDTH-1:0]        wb_dat_i;
    logic                         wb_we_o;
    logic [BPL-1:0]               wb_sel_o;
    logic                         wb_stb_o;
    logic                         wb_cyc_o;
    logic                         wb_ack_i;
    logic                         wb_err_i;
    logic                         wb_rty_i;

    // Controller view: serves requesters, masters the system bus.
    modport slave (
        input  req_valid, req_addr, req_wr, req_wdata, req_sel, inv_valid, inv_addr,
               wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
    );

    // Environment view: requesters plus the bus slave.
    modport master (
        output req_valid, req_addr, req_wr, req_wdata, req_sel, inv_valid, inv_addr,
               wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
    );

endinterface

// File: rtl/memcontrol_mp_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after ptr.
// Latency: combinational.
// Backpressure: no grant while en is low.
module rr_arbiter #(
    parameter int N = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          gnt_any
);
    int idx;

    // Scan ptr+1 .. ptr+N (mod N) and take the first active request.
    always_comb begin
        gnt     = '0;
        gnt_idx = ptr;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (en && !gnt_any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = PW'(idx);
                gnt_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/memcontrol_mp.sv
// Multi-port direct-mapped write-through line cache with a Wishbone master.
// Latency: read hit 2 cycles accept-to-response; misses and writes add bus time.
// Backpressure: one request in flight; req_ready only in IDLE for the granted port.
module memcontrol_mp
    import memcontrol_pkg::*;
#(
    parameter int NPORTS           = 2,
    parameter int ADDR_WIDTH       = 32,
    parameter int WORD_WIDTH       = 32,
    parameter int LINE_WIDTH       = 128,
    parameter int CACHE_DEPTH      = 9,
    parameter int ADDR_GRANULARITY = 8
) (
    input  logic           clk,
    input  logic           rst,
    memcontrol_mp_if.slave bus
);
    localparam int BPW    = WORD_WIDTH / ADDR_GRANULARITY;
    localparam int BPL    = LINE_WIDTH / ADDR_GRANULARITY;
    localparam int WPL    = word_depth(LINE_WIDTH, WORD_WIDTH);
    localparam int OFF_W  = off_width(LINE_WIDTH, ADDR_GRANULARITY);
    localparam int WSEL_W = $clog2(BPW);
    localparam int WPOS_W = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int TAG_W  = tag_width(ADDR_WIDTH, LINE_WIDTH, ADDR_GRANULARITY, CACHE_DEPTH);
    localparam int LINES  = line_depth(CACHE_DEPTH);
    localparam int PW     = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    logic [2:0]             state;
    logic [PW-1:0]          rr, r_port, gnt_idx;
    logic [NPORTS-1:0]      gnt, port_oh;
    logic                   gnt_any, accept;
    logic [ADDR_WIDTH-1:0]  r_addr, in_addr;
    logic                   r_wr, r_hit, rd_vld, hit, fill_ack, wr_merge, stb;
    logic [WORD_WIDTH-1:0]  r_wdata, hit_word, fill_word;
    logic [BPW-1:0]         r_sel;
    logic [TAG_W-1:0]       rd_tag, r_tag;
    logic [LINE_WIDTH-1:0]  rd_line, merged;
    logic [CACHE_DEPTH-1:0] in_idx, r_idx, inv_idx;
    logic [WPOS_W-1:0]      wpos;
    logic [BPL-1:0]         wmask;
    logic [NPORTS-1:0]      rsp_valid_q;
    logic [WORD_WIDTH-1:0]  rsp_rdata_q;
    logic                   rsp_err_q;
    logic [LINES-1:0]       valid;
    logic [TAG_W-1:0]       tag_mem  [LINES];
    logic [LINE_WIDTH-1:0]  line_mem [LINES];

    rr_arbiter #(.N(NPORTS)) u_arb (
        .req     (bus.req_valid),
        .en      (state == ST_IDLE),
        .ptr     (rr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign accept    = (state == ST_IDLE) && gnt_any;
    assign in_addr   = bus.req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign in_idx    = CACHE_DEPTH'(in_addr >> OFF_W);
    assign inv_idx   = CACHE_DEPTH'(bus.inv_addr >> OFF_W);
    assign r_idx     = CACHE_DEPTH'(r_addr >> OFF_W);
    assign r_tag     = TAG_W'(r_addr >> (OFF_W + CACHE_DEPTH));
    assign wpos      = WPOS_W'(r_addr[OFF_W-1:0] >> WSEL_W);
    assign hit       = rd_vld && (rd_tag == r_tag);
    assign hit_word  = WORD_WIDTH'(rd_line >> (wpos * WORD_WIDTH));
    assign fill_word = WORD_WIDTH'(bus.wb_dat_i >> (wpos * WORD_WIDTH));
    assign wmask     = BPL'(r_sel) << (wpos * BPW);
    assign port_oh   = NPORTS'(1) << r_port;
    assign stb       = (state == ST_FILL) || (state == ST_WRITE);
    assign fill_ack  = (state == ST_FILL) && bus.wb_ack_i;
    assign wr_merge  = (state == ST_WRITE) && bus.wb_ack_i && r_hit;

    // Bus outputs derive from captured request state, so they hold while stb is up.
    assign bus.req_ready = gnt;
    assign bus.wb_stb_o  = stb;
    assign bus.wb_cyc_o  = stb;
    assign bus.wb_we_o   = (state == ST_WRITE);
    assign bus.wb_adr_o  = {r_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    assign bus.wb_sel_o  = r_wr ? wmask : '1;
    assign bus.wb_dat_o  = {WPL{r_wdata}};
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    // Merge the enabled write bytes into the line copy read at accept time.
    always_comb begin
        merged = rd_line;
        for (int b = 0; b < BPL; b++) begin
            if (wmask[b]) begin
                merged[b*ADDR_GRANULARITY +: ADDR_GRANULARITY] =
                    bus.wb_dat_o[b*ADDR_GRANULARITY +: ADDR_GRANULARITY];
            end
        end
    end

    // Control FSM, request capture, round-robin pointer and response pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            rr          <= '0;
            r_port      <= '0;
            r_addr      <= '0;
            r_wr        <= 1'b0;
            r_wdata     <= '0;
            r_sel       <= '0;
            r_hit       <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt_any) begin
                        r_port  <= gnt_idx;
                        r_addr  <= in_addr;
                        r_wr    <= bus.req_wr[gnt_idx];
                        r_wdata <= bus.req_wdata[gnt_idx*WORD_WIDTH +: WORD_WIDTH];
                        r_sel   <= bus.req_sel[gnt_idx*BPW +: BPW];
                        rr      <= gnt_idx;
                        state   <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    r_hit <= hit;
                    if (r_wr) begin
                        state <= ST_WRITE;
                    end else if (hit) begin
                        rsp_valid_q <= port_oh;
                        rsp_rdata_q <= hit_word;
                        state       <= ST_IDLE;
                    end else begin
                        state <= ST_FILL;
                    end
                end
                ST_FILL, ST_WRITE: begin
                    if (bus.wb_ack_i) begin
                        rsp_valid_q <= port_oh;
                        rsp_rdata_q <= (state == ST_FILL) ? fill_word : '0;
                        state       <= ST_IDLE;
                    end else if (bus.wb_err_i) begin
                        rsp_valid_q <= port_oh;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        state       <= ST_IDLE;
                    end else if (bus.wb_rty_i) begin
                        state <= ST_RETRY;
                    end
                end
                ST_RETRY: state <= r_wr ? ST_WRITE : ST_FILL;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Valid bits: fills set, invalidates clear afterwards so an invalidate wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid  <= '0;
            rd_vld <= 1'b0;
        end else begin
            if (accept) begin
                rd_vld <= valid[in_idx] && !(bus.inv_valid && (inv_idx == in_idx));
            end
            if (fill_ack) begin
                valid[r_idx] <= 1'b1;
            end
            if (bus.inv_valid) begin
                valid[inv_idx] <= 1'b0;
            end
        end
    end

    // Tag/line arrays: synchronous read on accept, write on fill or write-hit merge.
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_tag  <= tag_mem[in_idx];
            rd_line <= line_mem[in_idx];
        end
        if (fill_ack) begin
            tag_mem[r_idx]  <= r_tag;
            line_mem[r_idx] <= bus.wb_dat_i;
        end else if (wr_merge) begin
            line_mem[r_idx] <= merged;
        end
    end

endmodule

// File: tb/tb_memcontrol_mp.sv
// Directed bench for memcontrol_mp acting as both requesters and the Wishbone slave.
// Latency: n/a.
// Backpressure: n/a.
module tb_memcontrol_mp;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [1:0]  eg;
    logic [31:0] ed;

    localparam logic [127:0] L1  = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] L1M = 128'h44444444_33333333_DEADBEAA_11111111;
    localparam logic [127:0] L2  = 128'h88888888_77777777_66666666_55555555;

    memcontrol_mp_if bus ();
    memcontrol_mp dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request and wait for it to be accepted; returns at accept edge + 1.
    task automatic send(input int p, input logic [31:0] a, input logic wr,
                        input logic [31:0] d, input logic [3:0] s);
        int n;
        @(posedge clk); #1;
        bus.req_addr[p*32 +: 32]  = a;
        bus.req_wr[p]             = wr;
        bus.req_wdata[p*32 +: 32] = d;
        bus.req_sel[p*4 +: 4]     = s;
        bus.req_valid[p]          = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.req_ready[p] && n < 20);
        chk("accept", 128'(bus.req_ready[p]), 128'd1);
        @(posedge clk); #1;
        bus.req_valid[p] = 1'b0;
    endtask

    // Wait for a bus strobe and check the presented transaction.
    task automatic bus_wait(input string tag, input logic [31:0] adr, input logic we,
                            input logic [15:0] sel);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.wb_stb_o && n < 20);
        chk({tag, ".stb"}, 128'(bus.wb_stb_o), 128'd1);
        chk({tag, ".cyc"}, 128'(bus.wb_cyc_o), 128'd1);
        chk({tag, ".adr"}, 128'(bus.wb_adr_o), 128'(adr));
        chk({tag, ".we"},  128'(bus.wb_we_o),  128'(we));
        chk({tag, ".sel"}, 128'(bus.wb_sel_o), 128'(sel));
    endtask

    // Terminate the bus cycle: kind 0=ack, 1=err, 2=rty.
    task automatic bus_reply(input int kind, input logic [127:0] data);
        bus.wb_dat_i = data;
        bus.wb_ack_i = (kind == 0);
        bus.wb_err_i = (kind == 1);
        bus.wb_rty_i = (kind == 2);
        @(posedge clk); #1;
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b0;
        bus.wb_rty_i = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int p, input logic chk_d,
                            input logic [31:0] d, input logic err);
        int n;
        logic [1:0] oh;
        oh = 2'(1 << p);
        n = 0;
        do begin @(negedge clk); n++; end while (bus.rsp_valid == 2'b00 && n < 20);
        chk({tag, ".rsp_valid"}, 128'(bus.rsp_valid), 128'(oh));
        chk({tag, ".rsp_err"},   128'(bus.rsp_err),   128'(err));
        if (chk_d) chk({tag, ".rsp_rdata"}, 128'(bus.rsp_rdata), 128'(d));
    endtask

    // Read expected to hit: response exactly two cycles after accept, no bus activity.
    task automatic hit_read(input string tag, input int p, input logic [31:0] a,
                            input logic [31:0] d);
        logic [1:0] oh;
        oh = 2'(1 << p);
        send(p, a, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        chk({tag, ".c1_rsp"}, 128'(bus.rsp_valid), 128'd0);
        chk({tag, ".c1_stb"}, 128'(bus.wb_stb_o),  128'd0);
        @(negedge clk);
        chk({tag, ".c2_rsp"},   128'(bus.rsp_valid), 128'(oh));
        chk({tag, ".c2_rdata"}, 128'(bus.rsp_rdata), 128'(d));
        chk({tag, ".c2_err"},   128'(bus.rsp_err),   128'd0);
        chk({tag, ".c2_stb"},   128'(bus.wb_stb_o),  128'd0);
    endtask

    task automatic miss_read(input string tag, input int p, input logic [31:0] a,
                             input logic [127:0] line, input logic [31:0] d);
        send(p, a, 1'b0, 32'h0, 4'h0);
        bus_wait(tag, {a[31:4], 4'h0}, 1'b0, 16'hFFFF);
        bus_reply(0, line);
        wait_rsp(tag, p, 1'b1, d, 1'b0);
    endtask

    initial begin
        bus.req_valid = '0; bus.req_addr = '0; bus.req_wr = '0;
        bus.req_wdata = '0; bus.req_sel = '0;
        bus.inv_valid = 1'b0; bus.inv_addr = '0;
        bus.wb_dat_i = '0; bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_rty_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst.req_ready", 128'(bus.req_ready), 128'd0);
        chk("rst.rsp_valid", 128'(bus.rsp_valid), 128'd0);
        chk("rst.rsp_err",   128'(bus.rsp_err),   128'd0);
        chk("rst.stb",       128'(bus.wb_stb_o),  128'd0);
        chk("rst.cyc",       128'(bus.wb_cyc_o),  128'd0);
        chk("rst.we",        128'(bus.wb_we_o),   128'd0);

        // 1: cold miss fill, then a hit in the same line.
        miss_read("t1_fill", 0, 32'h104, L1, 32'h22222222);
        hit_read("t1_hit", 0, 32'h108, 32'h33333333);

        // 2: write hits merge into the cached line.
        send(0, 32'h104, 1'b1, 32'hDEADBEEF, 4'hF);
        bus_wait("t2_w1", 32'h100, 1'b1, 16'h00F0);
        chk("t2_w1.dat", 128'(bus.wb_dat_o[63:32]), 128'h0DEADBEEF);
        bus_reply(0, '0);
        wait_rsp("t2_w1", 0, 1'b0, 32'h0, 1'b0);
        send(0, 32'h104, 1'b1, 32'h000000AA, 4'h1);
        bus_wait("t2_w2", 32'h100, 1'b1, 16'h0010);
        chk("t2_w2.dat", 128'(bus.wb_dat_o[39:32]), 128'hAA);
        bus_reply(0, '0);
        wait_rsp("t2_w2", 0, 1'b0, 32'h0, 1'b0);
        hit_read("t2_hit", 0, 32'h104, 32'hDEADBEAA);

        // 3: both ports stream hits; rr was left at 0, so port 1 is granted first.
        @(posedge clk); #1;
        bus.req_addr = {32'h10C, 32'h108};
        bus.req_wr = 2'b00;
        bus.req_valid = 2'b11;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            eg = i[0] ? 2'b01 : 2'b10;
            ed = i[0] ? 32'h33333333 : 32'h44444444;
            chk("t3.grant", 128'(bus.req_ready), 128'(eg));
            @(negedge clk);
            @(negedge clk);
            chk("t3.rsp_owner", 128'(bus.rsp_valid), 128'(eg));
            chk("t3.rsp_rdata", 128'(bus.rsp_rdata), 128'(ed));
        end
        bus.req_valid = 2'b00;

        // 4: conflict refills and a non-allocating write miss.
        miss_read("t4_conf", 1, 32'h2100, L2, 32'h55555555);
        miss_read("t4_back", 0, 32'h100, L1M, 32'h11111111);
        send(0, 32'h3100, 1'b1, 32'h12345678, 4'hF);
        bus_wait("t4_wmiss", 32'h3100, 1'b1, 16'h000F);
        bus_reply(0, '0);
        wait_rsp("t4_wmiss", 0, 1'b0, 32'h0, 1'b0);
        hit_read("t4_noalloc", 0, 32'h100, 32'h11111111);

        // 5: invalidate, error fill, retry fill.
        @(posedge clk); #1;
        bus.inv_valid = 1'b1;
        bus.inv_addr = 32'h10C;
        @(posedge clk); #1;
        bus.inv_valid = 1'b0;
        send(0, 32'h100, 1'b0, 32'h0, 4'h0);
        bus_wait("t5_inv", 32'h100, 1'b0, 16'hFFFF);
        bus_reply(1, '0);
        wait_rsp("t5_err", 0, 1'b0, 32'h0, 1'b1);
        send(0, 32'h100, 1'b0, 32'h0, 4'h0);
        bus_wait("t5_after_err", 32'h100, 1'b0, 16'hFFFF);
        bus_reply(2, '0);
        @(negedge clk);
        chk("t5_rty.gap_stb", 128'(bus.wb_stb_o), 128'd0);
        chk("t5_rty.gap_cyc", 128'(bus.wb_cyc_o), 128'd0);
        @(negedge clk);
        chk("t5_rty.re_stb", 128'(bus.wb_stb_o), 128'd1);
        chk("t5_rty.re_adr", 128'(bus.wb_adr_o), 128'h100);
        chk("t5_rty.re_we",  128'(bus.wb_we_o),  128'd0);
        chk("t5_rty.re_sel", 128'(bus.wb_sel_o), 128'hFFFF);
        bus_reply(0, L1M);
        wait_rsp("t5_rty", 0, 1'b1, 32'h11111111, 1'b0);
        hit_read("t5_refilled", 0, 32'h104, 32'hDEADBEAA);

        // 6: reset in the middle of a fill.
        send(0, 32'h200, 1'b0, 32'h0, 4'h0);
        bus_wait("t6_fill", 32'h200, 1'b0, 16'hFFFF);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst.stb", 128'(bus.wb_stb_o),  128'd0);
        chk("t6_rst.cyc", 128'(bus.wb_cyc_o),  128'd0);
        chk("t6_rst.rsp", 128'(bus.rsp_valid), 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        bus_reply(0, L2);
        @(negedge clk);
        chk("t6_late_ack.rsp", 128'(bus.rsp_valid), 128'd0);
        chk("t6_late_ack.stb", 128'(bus.wb_stb_o),  128'd0);
        @(negedge clk);
        chk("t6_late_ack.rsp2", 128'(bus.rsp_valid), 128'd0);
        miss_read("t6_reread", 0, 32'h104, L1M, 32'hDEADBEAA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
